// File: rtl/mac_10g_xgmii_tx.sv
// mac_10g_xgmii_tx -- 10G MAC transmit framer feeding an XGMII-input PCS.
//
// Turns a 64-bit valid/ready frame stream (FCS already present) into XGMII
// txd/txc words: /S/+preamble+SFD word, data words, /T/ (either packed in
// the last data word or as a separate terminate word), then enough idle
// words to honour IFG_BYTES. Any framing fault (bad keep, underrun) emits
// an all-/E/ word and the rest of the frame is drained silently.
//
// Ports:
//   clk, nreset          clock, asynchronous active-low reset
//   valid_i/ready_o      upstream handshake (ready_o is combinational)
//   data_i, keep_i       frame bytes, lane 0 first on the wire
//   last_i               final word of frame
//   pcs_ready_i          PCS sample enable; low = whole block stalls
//   xgmii_txd_o/txc_o    registered XGMII data / control
//   frame_cnt_o          good frames terminated (MAC_TX_STATS_EN only)
//   err_cnt_o            error words emitted    (MAC_TX_STATS_EN only)
//
// Build option: define MAC_TX_STATS_EN to add the saturating counters.

// Terminate-word byte for one lane: data below lane k, /T/ at lane k,
// /I/ above it.
module mac_10g_xgmii_tx_lane #(
  parameter int LANE = 0
) (
  input  logic [7:0] data,
  input  logic [3:0] k,
  output logic [7:0] txd,
  output logic       txc
);
  localparam logic [3:0] LN = 4'(LANE);

  always_comb begin
    txd = 8'h07;
    txc = 1'b1;
    if (LN < k) begin
      txd = data;
      txc = 1'b0;
    end else if (LN == k) begin
      txd = 8'hFD;
    end
  end
endmodule

module mac_10g_xgmii_tx #(
  parameter int XGMII_DATA_W = 64,
  parameter int XGMII_CTRL_W = 8,
  parameter int IFG_BYTES    = 12
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    valid_i,
  input  logic [XGMII_DATA_W-1:0] data_i,
  input  logic [XGMII_CTRL_W-1:0] keep_i,
  input  logic                    last_i,
  output logic                    ready_o,
  input  logic                    pcs_ready_i,
  output logic [XGMII_DATA_W-1:0] xgmii_txd_o,
  output logic [XGMII_CTRL_W-1:0] xgmii_txc_o
`ifdef MAC_TX_STATS_EN
  ,
  output logic [31:0]             frame_cnt_o,
  output logic [15:0]             err_cnt_o
`endif
);
  localparam int NUM_LANES = XGMII_CTRL_W;
  localparam int CNT_W     = 8;

  localparam logic [XGMII_DATA_W-1:0] IDLE_D = 64'h0707070707070707;
  localparam logic [XGMII_DATA_W-1:0] ERR_D  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [XGMII_DATA_W-1:0] PRE_D  = 64'hD5555555555555FB;
  localparam logic [XGMII_DATA_W-1:0] TERM_D = 64'h07070707070707FD;
  localparam logic [XGMII_CTRL_W-1:0] KEEP_ONE = {{(XGMII_CTRL_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_ABORT, S_TERM, S_IFG} state_t;

  state_t                  state, state_n;
  logic [XGMII_DATA_W-1:0] txd_n;
  logic [XGMII_CTRL_W-1:0] txc_n;
  logic [CNT_W-1:0]        cnt, cnt_n;

  function automatic logic [3:0] popcnt(input logic [XGMII_CTRL_W-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < XGMII_CTRL_W; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

  // Idle words still owed after a terminate word carrying k data bytes;
  // the /T/ and trailing /I/ bytes of that word already count as gap.
  function automatic logic [CNT_W-1:0] ifg_words(input logic [3:0] k);
    int gap;
    gap = IFG_BYTES - 8 + int'(k);
    if (gap <= 0) return '0;
    return CNT_W'((gap + 7) / 8);
  endfunction

  logic [3:0] keep_k;
  logic       keep_ok;
  assign keep_k  = popcnt(keep_i);
  // Contiguous from lane 0 <=> keep+1 has no bit in common with keep.
  assign keep_ok = (keep_i != '0) && ((keep_i & (keep_i + KEEP_ONE)) == '0);

  logic [XGMII_DATA_W-1:0] term_d;
  logic [XGMII_CTRL_W-1:0] term_c;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mac_10g_xgmii_tx_lane #(.LANE(g)) u_lane (
      .data (data_i[8*g +: 8]),
      .k    (keep_k),
      .txd  (term_d[8*g +: 8]),
      .txc  (term_c[g])
    );
  end

  assign ready_o = pcs_ready_i && (state == S_DATA || state == S_ABORT);

  always_comb begin
    state_n = state;
    txd_n   = xgmii_txd_o;
    txc_n   = xgmii_txc_o;
    cnt_n   = cnt;
    if (pcs_ready_i) begin
      unique case (state)
        S_IDLE: begin
          txd_n = IDLE_D;
          txc_n = '1;
          if (valid_i) begin
            txd_n   = PRE_D;
            txc_n   = 8'h01;
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          if (!valid_i || (!last_i && keep_i != '1) || (last_i && !keep_ok)) begin
            txd_n   = ERR_D;
            txc_n   = '1;
            // A bad last word has already ended the frame: nothing to drain.
            state_n = (valid_i && last_i) ? S_TERM : S_ABORT;
          end else if (!last_i || keep_k == 4'd8) begin
            txd_n   = data_i;
            txc_n   = '0;
            if (last_i) state_n = S_TERM;
          end else begin
            txd_n   = term_d;
            txc_n   = term_c;
            cnt_n   = ifg_words(keep_k);
            state_n = (ifg_words(keep_k) == '0) ? S_IDLE : S_IFG;
          end
        end
        S_ABORT: begin
          txd_n = IDLE_D;
          txc_n = '1;
          if (valid_i && last_i) state_n = S_TERM;
        end
        S_TERM: begin
          txd_n   = TERM_D;
          txc_n   = '1;
          cnt_n   = ifg_words(4'd0);
          state_n = (ifg_words(4'd0) == '0) ? S_IDLE : S_IFG;
        end
        S_IFG: begin
          txd_n = IDLE_D;
          txc_n = '1;
          if (cnt <= CNT_W'(1)) begin
            cnt_n   = '0;
            state_n = S_IDLE;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      xgmii_txd_o <= IDLE_D;
      xgmii_txc_o <= '1;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      xgmii_txd_o <= txd_n;
      xgmii_txc_o <= txc_n;
    end
  end

`ifdef MAC_TX_STATS_EN
  logic frm_err, err_pulse, term_pulse;

  always_comb begin
    err_pulse  = 1'b0;
    term_pulse = 1'b0;
    if (pcs_ready_i) begin
      if (state == S_DATA) begin
        if (!valid_i)     err_pulse  = 1'b1;
        else if (!last_i) err_pulse  = (keep_i != '1);
        else if (!keep_ok) err_pulse = 1'b1;
        else              term_pulse = (keep_k != 4'd8); // k=8 terminates from TERM
      end else if (state == S_TERM) begin
        term_pulse = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      frm_err     <= 1'b0;
      frame_cnt_o <= '0;
      err_cnt_o   <= '0;
    end else begin
      if (pcs_ready_i && state == S_IDLE && valid_i) frm_err <= 1'b0;
      else if (err_pulse)                            frm_err <= 1'b1;
      if (term_pulse && !frm_err && frame_cnt_o != '1) frame_cnt_o <= frame_cnt_o + 32'd1;
      if (err_pulse && err_cnt_o != '1)                err_cnt_o   <= err_cnt_o + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mac_10g_xgmii_tx.sv
// Self-checking bench for mac_10g_xgmii_tx. Frames are described as byte
// lists; the expected XGMII word stream is derived from those bytes (byte
// stream + /T/ + /I/ padding + minimum-gap idle words) and compared against
// the words the DUT presents on cycles the PCS actually samples.
module tb_mac_10g_xgmii_tx;
  localparam int IFG = 12;
  localparam logic [71:0] W_IDLE = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] W_PRE  = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] W_ERR  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
  localparam logic [71:0] W_TERM = {8'hFF, 64'h07070707070707FD};

  logic        clk = 1'b0;
  logic        nreset, valid_i, last_i, pcs_ready_i, ready_o;
  logic [63:0] data_i, xgmii_txd_o;
  logic [7:0]  keep_i, xgmii_txc_o;
`ifdef MAC_TX_STATS_EN
  logic [31:0] frame_cnt_o;
  logic [15:0] err_cnt_o;
`endif

  always #5 clk = ~clk;

  mac_10g_xgmii_tx dut (
    .clk         (clk),
    .nreset      (nreset),
    .valid_i     (valid_i),
    .data_i      (data_i),
    .keep_i      (keep_i),
    .last_i      (last_i),
    .ready_o     (ready_o),
    .pcs_ready_i (pcs_ready_i),
    .xgmii_txd_o (xgmii_txd_o),
    .xgmii_txc_o (xgmii_txc_o)
`ifdef MAC_TX_STATS_EN
    ,
    .frame_cnt_o (frame_cnt_o),
    .err_cnt_o   (err_cnt_o)
`endif
  );

  int          n_chk = 0, n_pass = 0;
  logic [71:0] cap_q[$], exp_q[$];
  int          frm_len[$];
  logic [7:0]  frm_byte[$];
  bit          cap_en = 1'b0;
  int          hold_viol = 0, rdy_viol = 0, cyc = 0;
  int          exp_frm = 0, exp_err = 0;
  logic [71:0] prev_out;

  // Capture one word per PCS-sampled edge; on stalled edges the outputs
  // must not move.
  always @(posedge clk) begin
    bit          en, pr;
    logic [71:0] cur;
    en = cap_en;
    pr = pcs_ready_i;
    #1;
    cur = {xgmii_txc_o, xgmii_txd_o};
    if (en) begin
      if (pr) cap_q.push_back(cur);
      else if (cur !== prev_out) hold_viol++;
    end
    prev_out = cur;
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int gap_words(input int t_bytes);
    int need;
    need = IFG - t_bytes;
    return (need <= 0) ? 0 : (need + 7) / 8;
  endfunction

  task automatic add_frame(input int len);
    frm_len.push_back(len);
    for (int i = 0; i < len; i++) frm_byte.push_back(8'($urandom));
  endtask

  task automatic clear_frames();
    frm_len.delete();
    frm_byte.delete();
  endtask

  // Expected wire stream. Frame 0 may be aborted by an underrun before
  // word drop_at: its earlier words go out, then /E/, one idle per drained
  // word, a full terminate word and the gap.
  task automatic build_exp(input int drop_at);
    int bp;
    bp = 0;
    exp_q.delete();
    foreach (frm_len[f]) begin
      int         len, nw;
      logic [7:0] sb[$];
      bit         sc[$];
      len = frm_len[f];
      nw  = (len + 7) / 8;
      exp_q.push_back(W_PRE);
      if (f == 0 && drop_at >= 0) begin
        for (int i = 0; i < 8 * drop_at; i++) begin
          sb.push_back(frm_byte[bp + i]);
          sc.push_back(1'b0);
        end
      end else begin
        for (int i = 0; i < len; i++) begin
          sb.push_back(frm_byte[bp + i]);
          sc.push_back(1'b0);
        end
        sb.push_back(8'hFD);
        sc.push_back(1'b1);
        while (sb.size() % 8 != 0) begin
          sb.push_back(8'h07);
          sc.push_back(1'b1);
        end
      end
      for (int w = 0; w < sb.size() / 8; w++) begin
        logic [71:0] wd;
        for (int l = 0; l < 8; l++) begin
          wd[8*l +: 8] = sb[8*w + l];
          wd[64 + l]   = sc[8*w + l];
        end
        exp_q.push_back(wd);
      end
      if (f == 0 && drop_at >= 0) begin
        exp_q.push_back(W_ERR);
        for (int w = drop_at; w < nw; w++) exp_q.push_back(W_IDLE);
        exp_q.push_back(W_TERM);
        for (int i = 0; i < gap_words(8); i++) exp_q.push_back(W_IDLE);
        exp_err++;
      end else begin
        for (int i = 0; i < gap_words(8 - len % 8); i++) exp_q.push_back(W_IDLE);
        exp_frm++;
      end
      bp += len;
    end
  endtask

  // stall_mode: 0 none, 1 one cycle in 32, 2 random ~25%.
  task automatic run(input string tag, input int stall_mode, input int drop_at);
    int bp;
    bit tmo;
    bp  = 0;
    tmo = 1'b0;
    build_exp(drop_at);
    cap_q.delete();
    hold_viol = 0;
    rdy_viol  = 0;
    foreach (frm_len[f]) begin
      int len, nw;
      len = frm_len[f];
      nw  = (len + 7) / 8;
      for (int w = 0; w < nw; w++) begin
        int nb, guard;
        bit x;
        nb    = (len - 8 * w > 8) ? 8 : len - 8 * w;
        guard = 0;
        if (f == 0 && w == drop_at) begin
          @(negedge clk);
          valid_i     = 1'b0;
          pcs_ready_i = 1'b1;
          @(posedge clk);
        end
        do begin
          @(negedge clk);
          cyc++;
          case (stall_mode)
            1:       pcs_ready_i = (cyc % 32 != 5);
            2:       pcs_ready_i = ($urandom_range(3) != 0);
            default: pcs_ready_i = 1'b1;
          endcase
          valid_i = 1'b1;
          for (int l = 0; l < 8; l++)
            data_i[8*l +: 8] = (l < nb) ? frm_byte[bp + 8*w + l] : 8'($urandom);
          keep_i = 8'((1 << nb) - 1);
          last_i = (w == nw - 1);
          cap_en = 1'b1;
          #1;
          if (!pcs_ready_i && ready_o) rdy_viol++;
          x = valid_i && ready_o;
          @(posedge clk);
          guard++;
        end while (!x && guard < 200);
        if (!x) tmo = 1'b1;
      end
      bp += len;
    end
    @(negedge clk);
    valid_i     = 1'b0;
    last_i      = 1'b0;
    pcs_ready_i = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    cap_en = 1'b0;
    chk({tag, " timeout"}, 72'(tmo), 72'(0));
    chk({tag, " hold"}, 72'(hold_viol), 72'(0));
    chk({tag, " ready_stall"}, 72'(rdy_viol), 72'(0));
    chk({tag, " len_ok"}, 72'(cap_q.size() >= exp_q.size()), 72'(1));
    foreach (exp_q[i]) chk($sformatf("%s word%0d", tag, i), cap_q[i], exp_q[i]);
    for (int i = exp_q.size(); i < cap_q.size(); i++)
      chk($sformatf("%s tail%0d", tag, i), cap_q[i], W_IDLE);
  endtask

  // Every /T/-to-/S/ gap must be at least IFG bytes and /S/ in lane 0.
  task automatic check_gaps(input string tag);
    int gap;
    gap = -1;
    foreach (cap_q[i]) begin
      for (int l = 0; l < 8; l++) begin
        bit         c;
        logic [7:0] b;
        c = cap_q[i][64 + l];
        b = cap_q[i][8*l +: 8];
        if (c && b == 8'hFD) gap = 0;
        if (gap >= 0 && c && (b == 8'hFD || b == 8'h07)) gap++;
        else if (c && b == 8'hFB) begin
          if (gap >= 0) begin
            chk({tag, " gap"}, 72'(gap >= IFG), 72'(1));
            chk({tag, " sop_lane"}, 72'(l), 72'(0));
          end
          gap = -1;
        end
      end
    end
  endtask

  initial begin
    nreset      = 1'b0;
    valid_i     = 1'b0;
    last_i      = 1'b0;
    pcs_ready_i = 1'b1;
    data_i      = '0;
    keep_i      = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst txd", 72'(xgmii_txd_o), 72'(64'h0707070707070707));
    chk("rst txc", 72'(xgmii_txc_o), 72'(8'hFF));
    chk("rst ready", 72'(ready_o), 72'(0));
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    chk("idle ready", 72'(ready_o), 72'(0));
`ifdef MAC_TX_STATS_EN
    chk("rst frame_cnt", 72'(frame_cnt_o), 72'(0));
    chk("rst err_cnt", 72'(err_cnt_o), 72'(0));
`endif

    // k=4 packed terminate, k=0 separate terminate word, k=7 two idles.
    clear_frames();
    add_frame(20);
    add_frame(16);
    add_frame(23);
    run("basic", 0, -1);
    chk("basic t_txc", 72'(cap_q[3][71:64]), 72'(8'hF0));
    chk("basic t_lane4", 72'(cap_q[3][39:32]), 72'(8'hFD));
    chk("basic term_word", cap_q[8], W_TERM);
    chk("basic k7_txc", 72'(cap_q[13][71:64]), 72'(8'h80));
    chk("basic k7_idle2", cap_q[15], W_IDLE);
    chk("basic next_sop", cap_q[16], W_IDLE);
    check_gaps("basic");

    // 20-word frame with periodic PCS stalls.
    clear_frames();
    add_frame(160);
    add_frame(20);
    run("stall32", 1, -1);
    check_gaps("stall32");

    // Underrun mid-frame, then a clean frame.
    clear_frames();
    add_frame(32);
    add_frame(12);
    run("underrun", 0, 2);
    check_gaps("underrun");
`ifdef MAC_TX_STATS_EN
    chk("underrun err_cnt", 72'(err_cnt_o), 72'(exp_err));
`endif

    // Random lengths, back-to-back, random stalls.
    clear_frames();
    for (int i = 0; i < 6; i++) add_frame(int'($urandom_range(64, 1)));
    run("random", 2, -1);
    check_gaps("random");
`ifdef MAC_TX_STATS_EN
    chk("frame_cnt", 72'(frame_cnt_o), 72'(exp_frm));
`endif

    // Reset in the middle of a frame.
    @(negedge clk);
    valid_i     = 1'b1;
    pcs_ready_i = 1'b1;
    data_i      = {$urandom, $urandom};
    keep_i      = 8'hFF;
    last_i      = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    chk("midrst txd", 72'(xgmii_txd_o), 72'(64'h0707070707070707));
    chk("midrst txc", 72'(xgmii_txc_o), 72'(8'hFF));
    chk("midrst ready", 72'(ready_o), 72'(0));
    @(negedge clk);
    valid_i = 1'b0;
    nreset  = 1'b1;
    exp_frm = 0;
    exp_err = 0;
    clear_frames();
    add_frame(10);
    run("post_rst", 0, -1);
`ifdef MAC_TX_STATS_EN
    chk("post_rst frame_cnt", 72'(frame_cnt_o), 72'(exp_frm));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
